// File: rtl/obi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : obi_arb_pkg
// Description : Shared types and helpers for the OBI round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package obi_arb_pkg;

  // Largest supported requester count; obi_arb_idx_t must hold 0..MAX_REQ-1.
  localparam int MAX_REQ = 8;

  // Requester index as stored in the response-routing FIFO.
  typedef logic [2:0] obi_arb_idx_t;

  // Width of a requester index; never below one bit so NUM_REQ=1 stays legal.
  function automatic int idx_w(input int n);
    if (n > 1) return $clog2(n);
    return 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/obi_arb_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : obi_arb_id_fifo
// Description : Synchronous FIFO holding requester indices in grant order.
//               Push while full and pop while empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module obi_arb_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Pointers wrap explicitly so a depth of 1 needs no special case.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign rdata  = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage array: contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/obi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : obi_rr_arbiter
// Description : Shares one OBI manager port between NUM_REQ requesters.
//               Selected requests are held until granted; responses are
//               routed back through an in-order ID FIFO.
//               Macro OBI_ARB_RR_EN: defined selects round-robin arbitration,
//               undefined selects fixed priority (lowest index wins).
// Revision    : 1.0 - initial release
// ============================================================================
module obi_rr_arbiter
  import obi_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int OBI_ADDRW = 32,
  parameter int OBI_DATAW = 32,
  parameter int OBI_STRBW = OBI_DATAW / 8,
  parameter int MAX_OUTST = 2
) (
  input  logic                               clk_i,
  input  logic                               srst_i,
  input  logic [NUM_REQ-1:0]                 req_i,
  input  logic [NUM_REQ-1:0][OBI_ADDRW-1:0]  addr_i,
  input  logic [NUM_REQ-1:0]                 we_i,
  input  logic [NUM_REQ-1:0][OBI_DATAW-1:0]  wdata_i,
  input  logic [NUM_REQ-1:0][OBI_STRBW-1:0]  be_i,
  output logic [NUM_REQ-1:0]                 gnt_o,
  output logic [NUM_REQ-1:0]                 rvalid_o,
  output logic [OBI_DATAW-1:0]               rdata_o,
  output logic                               m_req_o,
  output logic [OBI_ADDRW-1:0]               m_addr_o,
  output logic                               m_we_o,
  output logic [OBI_DATAW-1:0]               m_wdata_o,
  output logic [OBI_STRBW-1:0]               m_be_o,
  input  logic                               m_gnt_i,
  input  logic                               m_rvalid_i,
  input  logic [OBI_DATAW-1:0]               m_rdata_i
);

  localparam int IDX_W = idx_w(NUM_REQ);

  logic               r_lock;
  logic [IDX_W-1:0]   r_lock_idx;
  logic [IDX_W-1:0]   w_start;
  logic               w_arb_found;
  logic [IDX_W-1:0]   w_arb_idx;
  logic [IDX_W-1:0]   w_sel;
  logic               w_m_req;
  logic               w_hs;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  obi_arb_idx_t       w_head;
  obi_arb_idx_t       w_route_idx;
  logic               w_route_en;

`ifdef OBI_ARB_RR_EN
  logic [IDX_W-1:0]   r_rr_ptr;

  // Round-robin pointer: the requester after the one just granted gets top priority.
  always_ff @(posedge clk_i) begin
    if (srst_i)    r_rr_ptr <= '0;
    else if (w_hs) r_rr_ptr <= (w_sel == IDX_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
  end

  assign w_start = r_rr_ptr;
`else
  assign w_start = '0;
`endif

  // Priority scan: first active request starting at w_start, wrapping.
  always_comb begin
    int k;
    k           = 0;
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(w_start) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!w_arb_found && req_i[k]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = IDX_W'(k);
      end
    end
  end

  // A pending lock always wins; new arbitration only when free and not full.
  assign w_sel   = r_lock ? r_lock_idx : w_arb_idx;
  assign w_m_req = !srst_i && (r_lock || (!w_full && w_arb_found));
  assign w_hs    = w_m_req && m_gnt_i;

  assign m_req_o   = w_m_req;
  assign m_addr_o  = addr_i[w_sel];
  assign m_we_o    = we_i[w_sel];
  assign m_wdata_o = wdata_i[w_sel];
  assign m_be_o    = be_i[w_sel];

  // Lock the presented requester until the converter grants it.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_hs) begin
      r_lock     <= 1'b0;
    end else if (w_m_req && !r_lock) begin
      r_lock     <= 1'b1;
      r_lock_idx <= w_arb_idx;
    end
  end

  // With an empty FIFO, a same-cycle response bypasses it; otherwise push/pop
  // happen independently and a spurious response leaves the FIFO untouched.
  assign w_push = w_hs && !(w_empty && m_rvalid_i);
  assign w_pop  = !srst_i && m_rvalid_i && !w_empty;

  obi_arb_id_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH ($bits(obi_arb_idx_t))
  ) u_id_fifo (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .push   (w_push),
    .pop    (w_pop),
    .wdata  (obi_arb_idx_t'(w_sel)),
    .rdata  (w_head),
    .full   (w_full),
    .empty  (w_empty)
  );

  assign w_route_idx = w_empty ? obi_arb_idx_t'(w_sel) : w_head;
  assign w_route_en  = !srst_i && m_rvalid_i && (!w_empty || w_hs);
  assign rdata_o     = m_rdata_i;

  // One-hot grant and response demux towards the requesters.
  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_o[i]    = w_hs && (w_sel == IDX_W'(i));
      rvalid_o[i] = w_route_en && (w_route_idx == obi_arb_idx_t'(i));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_obi_rr_arbiter
// Description : Self-checking bench for obi_rr_arbiter: directed scenarios
//               followed by OBI-compliant random traffic, checked against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obi_rr_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int MO = 2;

  logic                  clk_i = 1'b0;
  logic                  srst_i;
  logic [N-1:0]          req_i;
  logic [N-1:0][AW-1:0]  addr_i;
  logic [N-1:0]          we_i;
  logic [N-1:0][DW-1:0]  wdata_i;
  logic [N-1:0][SW-1:0]  be_i;
  logic [N-1:0]          gnt_o;
  logic [N-1:0]          rvalid_o;
  logic [DW-1:0]         rdata_o;
  logic                  m_req_o;
  logic [AW-1:0]         m_addr_o;
  logic                  m_we_o;
  logic [DW-1:0]         m_wdata_o;
  logic [SW-1:0]         m_be_o;
  logic                  m_gnt_i;
  logic                  m_rvalid_i;
  logic [DW-1:0]         m_rdata_i;

  always #5 clk_i = ~clk_i;

  obi_rr_arbiter #(
    .NUM_REQ   (N),
    .OBI_ADDRW (AW),
    .OBI_DATAW (DW),
    .OBI_STRBW (SW),
    .MAX_OUTST (MO)
  ) u_dut (
    .clk_i      (clk_i),
    .srst_i     (srst_i),
    .req_i      (req_i),
    .addr_i     (addr_i),
    .we_i       (we_i),
    .wdata_i    (wdata_i),
    .be_i       (be_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .m_req_o    (m_req_o),
    .m_addr_o   (m_addr_o),
    .m_we_o     (m_we_o),
    .m_wdata_o  (m_wdata_o),
    .m_be_o     (m_be_o),
    .m_gnt_i    (m_gnt_i),
    .m_rvalid_i (m_rvalid_i),
    .m_rdata_i  (m_rdata_i)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: outstanding requesters in grant order, the
  // requester currently held waiting for grant, and the priority start point.
  int          mdl_q[$];
  bit          mdl_locked;
  int          mdl_lock_idx;
  logic [AW-1:0] mdl_lock_addr;
  int          mdl_ptr;
  logic [N-1:0] exp_gnt;
  bit          hold [N];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Check all outputs for the current inputs, then advance the model one clock.
  task automatic eval_and_check();
    int           sel;
    int           start;
    bit           mreq;
    bit           hs;
    bit           pop;
    logic [N-1:0] eg;
    logic [N-1:0] erv;
    sel  = 0;
    mreq = 1'b0;
    eg   = '0;
    erv  = '0;
    #2;
    if (srst_i) begin
      check_val("rst_mreq", 64'(m_req_o), 64'(0));
      check_val("rst_gnt", 64'(gnt_o), 64'(0));
      check_val("rst_rvalid", 64'(rvalid_o), 64'(0));
      mdl_q.delete();
      mdl_locked = 1'b0;
      mdl_ptr    = 0;
    end else begin
`ifdef OBI_ARB_RR_EN
      start = mdl_ptr;
`else
      start = 0;
`endif
      if (mdl_locked) begin
        mreq = 1'b1;
        sel  = mdl_lock_idx;
      end else if (mdl_q.size() < MO) begin
        for (int i = 0; i < N; i++) begin
          int k;
          k = (start + i) % N;
          if (!mreq && req_i[k]) begin
            mreq = 1'b1;
            sel  = k;
          end
        end
      end
      hs = mreq && m_gnt_i;
      if (hs) eg[sel] = 1'b1;
      if (m_rvalid_i) begin
        if (mdl_q.size() > 0) erv[mdl_q[0]] = 1'b1;
        else if (hs)          erv[sel]      = 1'b1;
      end
      check_val("mreq", 64'(m_req_o), 64'(mreq));
      check_val("gnt", 64'(gnt_o), 64'(eg));
      check_val("rvalid", 64'(rvalid_o), 64'(erv));
      check_val("rdata", 64'(rdata_o), 64'(m_rdata_i));
      if (mreq) begin
        check_val("maddr", 64'(m_addr_o), 64'(addr_i[sel]));
        check_val("mwe", 64'(m_we_o), 64'(we_i[sel]));
        check_val("mwdata", 64'(m_wdata_o), 64'(wdata_i[sel]));
        check_val("mbe", 64'(m_be_o), 64'(be_i[sel]));
        if (mdl_locked) check_val("stable_addr", 64'(m_addr_o), 64'(mdl_lock_addr));
      end
      pop = m_rvalid_i && (mdl_q.size() > 0);
      if (pop) void'(mdl_q.pop_front());
      if (hs && !(m_rvalid_i && !pop)) mdl_q.push_back(sel);
      if (hs) begin
        mdl_locked = 1'b0;
        mdl_ptr    = (sel + 1) % N;
      end else if (mreq && !mdl_locked) begin
        mdl_locked    = 1'b1;
        mdl_lock_idx  = sel;
        mdl_lock_addr = addr_i[sel];
      end
    end
    exp_gnt = eg;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic step();
    eval_and_check();
    tick();
  endtask

  task automatic idle_inputs();
    srst_i     = 1'b0;
    req_i      = '0;
    addr_i     = '0;
    we_i       = '0;
    wdata_i    = '0;
    be_i       = '0;
    m_gnt_i    = 1'b0;
    m_rvalid_i = 1'b0;
    m_rdata_i  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    srst_i = 1'b1;
    step();
    srst_i = 1'b0;
  endtask

  initial begin
    idle_inputs();
    srst_i = 1'b1;
    tick();
    // Reset values.
    step();
    srst_i = 1'b0;

    // Reset while a request is locked waiting for grant.
    req_i   = 2'b10;
    addr_i[1] = 32'h1111_0000;
    repeat (3) step();
    srst_i = 1'b1;
    step();
    srst_i  = 1'b0;
    req_i   = 2'b11;
    m_gnt_i = 1'b1;
    eval_and_check();
    check_val("rst_lock_next_gnt", 64'(gnt_o), 64'(2'b01));
    tick();

    // Continuous requests with same-cycle responses.
    do_reset();
    req_i      = 2'b11;
    m_gnt_i    = 1'b1;
    m_rvalid_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      m_rdata_i = DW'(c + 32'h100);
      eval_and_check();
`ifdef OBI_ARB_RR_EN
      check_val("alt_gnt", 64'(gnt_o), (c % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
`else
      check_val("alt_gnt", 64'(gnt_o), 64'(2'b01));
`endif
      check_val("alt_rvalid", 64'(rvalid_o), 64'(gnt_o));
      tick();
    end

    // Hold stability while the converter stalls.
    do_reset();
    req_i     = 2'b01;
    addr_i[0] = 32'hAB;
    addr_i[1] = 32'hCD;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) req_i = 2'b11;
      eval_and_check();
      check_val("hold_addr", 64'(m_addr_o), 64'(32'hAB));
      tick();
    end
    m_gnt_i = 1'b1;
    eval_and_check();
    check_val("hold_gnt", 64'(gnt_o), 64'(2'b01));
    check_val("hold_addr_gnt", 64'(m_addr_o), 64'(32'hAB));
    tick();

    // Back-pressure: FIFO full blocks arbitration until a response pops.
    do_reset();
    req_i   = 2'b11;
    m_gnt_i = 1'b1;
    step();
    step();
    eval_and_check();
    check_val("bp_full_mreq", 64'(m_req_o), 64'(0));
    tick();
    m_rvalid_i = 1'b1;
    m_rdata_i  = 32'h45;
    eval_and_check();
    check_val("bp_rvalid", 64'(rvalid_o), 64'(2'b01));
    check_val("bp_rdata", 64'(rdata_o), 64'(32'h45));
    tick();
    m_rvalid_i = 1'b0;
    m_gnt_i    = 1'b0;
    eval_and_check();
    check_val("bp_resume", 64'(m_req_o), 64'(1));
    tick();

    // Same-cycle bypass, then a spurious response, then normal routing.
    do_reset();
    req_i      = 2'b10;
    m_gnt_i    = 1'b1;
    m_rvalid_i = 1'b1;
    m_rdata_i  = 32'h69;
    eval_and_check();
    check_val("bypass_rvalid", 64'(rvalid_o), 64'(2'b10));
    tick();
    req_i   = 2'b00;
    m_gnt_i = 1'b0;
    eval_and_check();
    check_val("spurious_rvalid", 64'(rvalid_o), 64'(0));
    tick();
    req_i      = 2'b01;
    m_gnt_i    = 1'b1;
    m_rvalid_i = 1'b0;
    step();
    req_i      = 2'b00;
    m_rvalid_i = 1'b1;
    eval_and_check();
    check_val("after_spurious_rvalid", 64'(rvalid_o), 64'(2'b01));
    tick();

    // Random OBI-compliant traffic: a requester holds its request until granted.
    do_reset();
    for (int i = 0; i < N; i++) hold[i] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      srst_i = ($urandom_range(0, 99) < 1);
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) begin
          req_i[i]   = ($urandom_range(0, 99) < 60);
          addr_i[i]  = $urandom;
          we_i[i]    = 1'($urandom);
          wdata_i[i] = $urandom;
          be_i[i]    = SW'($urandom);
        end
      end
      m_gnt_i    = ($urandom_range(0, 99) < 50);
      m_rvalid_i = ($urandom_range(0, 99) < 35);
      m_rdata_i  = $urandom;
      eval_and_check();
      for (int i = 0; i < N; i++) hold[i] = !srst_i && req_i[i] && !exp_gnt[i];
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/obi_rr_arbiter.md
# obi_rr_arbiter

Shares one OBI manager port (the single upstream port of the OBI-to-AXI core) between `NUM_REQ` OBI requesters, e.g. instruction and data ports of both cores. It sits directly in front of the converter. It uses round-robin arbitration, holds each selected request stable until the converter grants it, and routes `rvalid`/`rdata` back to the originating requester through an in-order ID FIFO.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8).
- `OBI_ADDRW`, 32: address width.
- `OBI_DATAW`, 32: data width.
- `OBI_STRBW`, `OBI_DATAW/8`: byte-enable width.
- `MAX_OUTST`, 2: maximum granted-but-unanswered transactions (ID FIFO depth, power of 2, ≥1).
- `clk_i` in 1: the only clock. All state updates on its rising edge.
- `srst_i` in 1: synchronous reset, active-high.
- `req_i` in `[NUM_REQ]`: per-requester OBI request.
- `addr_i` in `[NUM_REQ][OBI_ADDRW]`: per-requester address.
- `we_i` in `[NUM_REQ]`: per-requester write enable.
- `wdata_i` in `[NUM_REQ][OBI_DATAW]`: per-requester write data.
- `be_i` in `[NUM_REQ][OBI_STRBW]`: per-requester byte enable.
- `gnt_o` out `[NUM_REQ]`: per-requester grant.
- `rvalid_o` out `[NUM_REQ]`: per-requester response valid.
- `rdata_o` out `[OBI_DATAW]`: read data, broadcast to all requesters.
- `m_req_o` out 1: request to the converter.
- `m_addr_o`, `m_we_o`, `m_wdata_o`, `m_be_o` out: fields of the selected requester.
- `m_gnt_i` in 1: converter grant.
- `m_rvalid_i` in 1: converter response valid.
- `m_rdata_i` in `[OBI_DATAW]`: converter read data.

## Operation
- State:
  - `lock_q`/`lock_idx_q`: a presented request is waiting for grant.
  - `rr_ptr_q`: highest-priority index.
  - ID FIFO: holds requester indices in grant order.
- Arbitration happens only when `lock_q`=0 and the FIFO is not full.
  - Pick the first `req_i[k]`=1 scanning from `rr_ptr_q` upward, wrapping modulo `NUM_REQ`.
  - `m_req_o`=1 and the `m_*` fields mux from k in the same cycle (combinational path `req_i` -> `m_req_o`).
- If `m_gnt_i`=0 in that cycle, set `lock_q`=1 and `lock_idx_q`=k.
  - While locked, `m_req_o`=1 and the fields come from `lock_idx_q`, whatever the other requesters do.
  - The lock clears on grant.
- Grant handshake (`m_req_o` && `m_gnt_i`):
  - `gnt_o[sel]`=1 in that cycle only.
  - Push `sel` into the FIFO.
  - `rr_ptr_q` <= (`sel`+1) mod `NUM_REQ`.
- FIFO full: `m_req_o`=0 and no new arbitration. A lock cannot exist while full, because a push only happens on grant.
- Response routing:
  - `rvalid_o[head]`=`m_rvalid_i`; all other bits are 0.
  - `rdata_o`=`m_rdata_i`.
  - Pop on `m_rvalid_i`.
- Simultaneous grant and rvalid:
  - FIFO empty: bypass. The response routes to the index being granted in that cycle; no net push.
  - FIFO non-empty: push and pop in the same cycle; occupancy unchanged.
- `m_rvalid_i` with FIFO empty and no same-cycle grant: protocol violation. The response is dropped, all `rvalid_o`=0, and FIFO state is unchanged.
- Reset (`srst_i`=1, including mid-transaction):
  - `lock_q`=0, `rr_ptr_q`=0, FIFO emptied.
  - Outputs forced to `gnt_o`=0, `rvalid_o`=0, `m_req_o`=0.
  - Outstanding transactions are abandoned. The environment must reset the converter together with this block.

## Timing
- Request-to-grant latency is 0 cycles added: `gnt_o` follows `m_gnt_i` combinationally.
- Response latency is 0 cycles added: `rvalid_o` follows `m_rvalid_i` combinationally.
- Registered state only: lock, pointer, FIFO. No combinational path from `m_rvalid_i` to `m_req_o`.
- `m_*` fields are stable from the first cycle of `m_req_o` until the grant cycle inclusive.
- Outputs in the first cycle after `srst_i` deasserts: same values as during reset unless `req_i` is active.

## Configuration
- `OBI_ARB_RR_EN` defined: round-robin arbitration as above.
- `OBI_ARB_RR_EN` undefined:
  - Fixed priority, lowest index wins.
  - `rr_ptr_q` is not implemented; the scan always starts at 0.
  - Lock, FIFO and routing behave identically.

## Structure
- `obi_arb_pkg` holds:
  - `localparam` `IDX_W = $clog2(NUM_REQ)` helper (function `idx_w`).
  - Typedef `obi_arb_idx_t` (logic `[2:0]`, wide enough for 8).
- Sub-module `obi_arb_id_fifo`:
  - Synchronous FIFO parameterised on depth and width.
  - Ports `push`, `pop`, `wdata`, `rdata`, `full`, `empty`, synchronous active-high reset.
  - The bypass logic lives in the parent.

## Test plan
- Reset mid-lock: `req_i[1]`=1, `m_gnt_i`=0 for 3 cycles, then `srst_i`=1 for 1 cycle -> `m_req_o`=0 and `gnt_o`=0 during reset; the next grant goes to index 0 if both requesters request.
- Both request continuously, `m_gnt_i`=1, `m_rvalid_i`=1 each cycle -> grants alternate 0,1,0,1 (fixed-priority build: always 0); `rvalid_o` follows the grant order.
- Hold stability: `req_i`=2'b01 with addr 0xAB, `m_gnt_i`=0 for 4 cycles, `req_i[1]` rises in cycle 2 -> `m_addr_o` stays 0xAB until grant; `gnt_o`=2'b01.
- Back-pressure: `MAX_OUTST`=2, two grants with no `m_rvalid_i` -> `m_req_o`=0 while `req_i`≠0; after one `m_rvalid_i` carrying 0x45, `rvalid_o` goes to the first granted requester with `rdata_o`=0x45, and arbitration resumes next cycle.
- Same-cycle bypass: FIFO empty, requester 1 granted and `m_rvalid_i`=1 with data 0x69 in the same cycle -> `rvalid_o`=2'b10, FIFO stays empty.
- Spurious `m_rvalid_i` with FIFO empty -> `rvalid_o`=0 and the following transaction is routed correctly.
